// File: rtl/fpu_inflight_tracker.sv
// fpu_inflight_tracker: per-stage bookkeeping of in-flight FPU instructions
// feeding the hazard detector, plus writeback strobe and occupancy.
module fpu_inflight_tracker #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_regwrite,
    input  logic [2:0]       issue_lat,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       flush_mask,
    output logic [REG_W-1:0] rdi_0,
    output logic [REG_W-1:0] rdi_1,
    output logic [REG_W-1:0] rdi_2,
    output logic [REG_W-1:0] rdi_3,
    output logic [REG_W-1:0] rdi_4,
    output logic             is_regwrite_0,
    output logic             is_regwrite_1,
    output logic             is_regwrite_2,
    output logic             is_regwrite_3,
    output logic             is_regwrite_4,
    output logic             is_legal_0,
    output logic             is_legal_1,
    output logic             is_legal_2,
    output logic             is_legal_3,
    output logic             is_legal_4,
    output logic             is_hazard_0,
    output logic             is_hazard_1,
    output logic             is_hazard_2,
    output logic             is_hazard_3,
    output logic             is_hazard_4,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [2:0]       inflight,
    output logic             busy
);
    logic [4:0]       legal, regwrite, hazard;
    logic [REG_W-1:0] rd [5];
    logic [2:0]       lat [5];
    logic [2:0]       lat_in;

    assign lat_in = issue_lat == 3'd0 ? 3'd1 : issue_lat > 3'd5 ? 3'd5 : issue_lat;

    // Flush squashes in place and takes priority over both shift and stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            legal    <= '0;
            regwrite <= '0;
            for (int i = 0; i < 5; i++) begin
                rd[i]  <= '0;
                lat[i] <= 3'd1;
            end
        end else if (flush) begin
            legal    <= legal & ~flush_mask;
            regwrite <= regwrite & ~flush_mask;
        end else if (!stall) begin
            legal    <= {legal[3:0], issue_valid};
            regwrite <= {regwrite[3:0], issue_valid & issue_regwrite};
            for (int i = 1; i < 5; i++) begin
                rd[i]  <= rd[i-1];
                lat[i] <= lat[i-1];
            end
            rd[0]  <= issue_valid ? issue_rd : '0;
            lat[0] <= issue_valid ? lat_in : 3'd1;
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_haz
        assign hazard[k] = legal[k] && (3'(k + 1) < lat[k]);
    end

    assign {rdi_0, rdi_1, rdi_2, rdi_3, rdi_4} = {rd[0], rd[1], rd[2], rd[3], rd[4]};
    assign {is_regwrite_4, is_regwrite_3, is_regwrite_2, is_regwrite_1, is_regwrite_0} = regwrite;
    assign {is_legal_4, is_legal_3, is_legal_2, is_legal_1, is_legal_0} = legal;
    assign {is_hazard_4, is_hazard_3, is_hazard_2, is_hazard_1, is_hazard_0} = hazard;
    assign wb_valid = legal[4] & regwrite[4] & ~stall & ~flush;
    assign wb_rd    = rd[4];
    assign inflight = 3'(legal[0]) + 3'(legal[1]) + 3'(legal[2]) + 3'(legal[3]) + 3'(legal[4]);
    assign busy     = |legal;
endmodule

// File: tb/tb_fpu_inflight_tracker.sv
// tb_fpu_inflight_tracker: directed and random stimulus checked against a
// list-of-instructions reference model.
module tb_fpu_inflight_tracker;
    logic       clk = 1'b0, rstn = 1'b0;
    logic       issue_valid = 1'b0, issue_regwrite = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [4:0] issue_rd = '0, flush_mask = '0;
    logic [2:0] issue_lat = 3'd1;
    logic [4:0] rdi [5];
    logic [4:0] rw_o, legal_o, haz_o;
    logic       wb_valid, busy;
    logic [4:0] wb_rd;
    logic [2:0] inflight;

    int n_checks = 0, n_fail = 0;

    typedef struct {
        int stage;
        int rd;
        bit rw;
        bit live;
        int lat;
    } ent_t;
    ent_t q[$];

    fpu_inflight_tracker #(.REG_W(5)) dut (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_lat(issue_lat), .stall(stall),
        .flush(flush), .flush_mask(flush_mask),
        .rdi_0(rdi[0]), .rdi_1(rdi[1]), .rdi_2(rdi[2]), .rdi_3(rdi[3]), .rdi_4(rdi[4]),
        .is_regwrite_0(rw_o[0]), .is_regwrite_1(rw_o[1]), .is_regwrite_2(rw_o[2]),
        .is_regwrite_3(rw_o[3]), .is_regwrite_4(rw_o[4]),
        .is_legal_0(legal_o[0]), .is_legal_1(legal_o[1]), .is_legal_2(legal_o[2]),
        .is_legal_3(legal_o[3]), .is_legal_4(legal_o[4]),
        .is_hazard_0(haz_o[0]), .is_hazard_1(haz_o[1]), .is_hazard_2(haz_o[2]),
        .is_hazard_3(haz_o[3]), .is_hazard_4(haz_o[4]),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int obs, int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the list of tracked instructions; an
    // unoccupied stage is a bubble reading rd=0, lat=1.
    task automatic check_all();
        int e_legal, e_rw, e_rd, e_haz, cnt, wbv, wbr;
        cnt = 0; wbv = 0; wbr = 0;
        for (int k = 0; k < 5; k++) begin
            e_legal = 0; e_rw = 0; e_rd = 0; e_haz = 0;
            foreach (q[i]) if (q[i].stage == k) begin
                e_legal = int'(q[i].live);
                e_rw    = int'(q[i].rw);
                e_rd    = q[i].rd;
                e_haz   = int'(q[i].live && (k + 1 < q[i].lat));
            end
            chk($sformatf("rdi_%0d", k), int'(rdi[k]), e_rd);
            chk($sformatf("is_regwrite_%0d", k), int'(rw_o[k]), e_rw);
            chk($sformatf("is_legal_%0d", k), int'(legal_o[k]), e_legal);
            chk($sformatf("is_hazard_%0d", k), int'(haz_o[k]), e_haz);
            cnt += e_legal;
            if (k == 4) begin
                wbr = e_rd;
                wbv = int'(e_legal == 1 && e_rw == 1 && !stall && !flush);
            end
        end
        chk("inflight", int'(inflight), cnt);
        chk("busy", int'(busy), int'(cnt != 0));
        chk("wb_valid", int'(wb_valid), wbv);
        chk("wb_rd", int'(wb_rd), wbr);
    endtask

    task automatic model_edge();
        int l;
        if (flush) begin
            foreach (q[i]) if (flush_mask[q[i].stage]) begin
                q[i].live = 1'b0;
                q[i].rw   = 1'b0;
            end
        end else if (!stall) begin
            foreach (q[i]) q[i].stage++;
            while (q.size() > 0 && q[0].stage > 4) void'(q.pop_front());
            if (issue_valid) begin
                l = int'(issue_lat);
                l = l == 0 ? 1 : l > 5 ? 5 : l;
                q.push_back('{0, int'(issue_rd), issue_regwrite, 1'b1, l});
            end
        end
    endtask

    task automatic cyc(bit v, int r, bit w, int l, bit st, bit fl, logic [4:0] fm);
        issue_valid = v; issue_rd = 5'(r); issue_regwrite = w; issue_lat = 3'(l);
        stall = st; flush = fl; flush_mask = fm;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 5'b0);
    endtask

    initial begin
        #1 check_all();
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        idle(5);
        // single issue, rd=7 lat=3
        cyc(1, 7, 1, 3, 0, 0, 5'b0);
        idle(4);
        #1 chk("single_wb_valid", int'(wb_valid), 1);
        chk("single_wb_rd", int'(wb_rd), 7);
        idle(2);
        chk("single_drained", int'(inflight), 0);
        // stall with entry in stage 1; issue during stall must be ignored
        cyc(1, 3, 1, 2, 0, 0, 5'b0);
        cyc(0, 0, 0, 1, 0, 0, 5'b0);
        for (int i = 0; i < 3; i++) cyc(1, 9, 1, 4, 1, 0, 5'b0);
        chk("stall_rdi_1", int'(rdi[1]), 3);
        chk("stall_inflight", int'(inflight), 1);
        idle(5);
        // flush during a full pipe
        for (int i = 1; i <= 5; i++) cyc(1, i, 1, 5, 0, 0, 5'b0);
        chk("flush_pre_inflight", int'(inflight), 5);
        cyc(0, 0, 0, 1, 0, 1, 5'b00011);
        chk("flush_post_inflight", int'(inflight), 3);
        chk("flush_rd_kept", int'(rdi[0]), 5);
        idle(6);
        // latency clamp
        cyc(1, 11, 1, 0, 0, 0, 5'b0);
        cyc(1, 12, 1, 7, 0, 0, 5'b0);
        idle(6);
        // reset with entries in flight
        for (int i = 0; i < 4; i++) cyc(1, 20 + i, 1, 5, 0, 0, 5'b0);
        issue_valid = 1'b0;
        #2 rstn = 1'b0;
        q.delete();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rstn = 1'b1;
        idle(6);
        // random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 99) < 60, int'($urandom_range(0, 31)), 1'($urandom),
                int'($urandom_range(0, 7)), $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 8, 5'($urandom));
        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
